adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 135 +++++++++++++
 tb/tb_adder_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Arbitrates two requesters onto one external adder. Each transaction runs
// LOAD, START, WAIT (with a watchdog) and RESP; outputs are registered from next state.
module adder_sched #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] res,
    output logic       err,
    output logic       busy,
    output logic       load,
    output logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] sum,
    input  logic       done
);

    localparam int unsigned DW  = 4;
    localparam int unsigned WDW = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]     state, state_n;
    logic [DW-1:0]  a_n, b_n, res_n;
    logic [WDW-1:0] wd, wd_n, wd_inc;
    logic           winner, winner_n;
    logic           last, last_n;
    logic           done_q;
    logic           ack0_n, ack1_n, err_n, busy_n, load_n, start_n;
    logic           done_rise, wd_expired;

    assign wd_inc     = wd + WDW'(1);
    assign wd_expired = (wd_inc == WDW'(TIMEOUT));
    assign done_rise  = done & ~done_q;

    // Registers: state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            A      <= '0;
            B      <= '0;
            wd     <= '0;
            winner <= 1'b0;
            last   <= 1'b1;
            done_q <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            res    <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            load   <= 1'b0;
            start  <= 1'b0;
        end else begin
            state  <= state_n;
            A      <= a_n;
            B      <= b_n;
            wd     <= wd_n;
            winner <= winner_n;
            last   <= last_n;
            done_q <= done;
            ack0   <= ack0_n;
            ack1   <= ack1_n;
            res    <= res_n;
            err    <= err_n;
            busy   <= busy_n;
            load   <= load_n;
            start  <= start_n;
        end
    end

    // Next state, datapath updates and next-cycle output decode
    always_comb begin
        state_n  = state;
        a_n      = A;
        b_n      = B;
        wd_n     = wd;
        winner_n = winner;
        last_n   = last;
        res_n    = '0;
        err_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to whoever was not served last
                    winner_n = (req0 && req1) ? ~last : req1;
                    a_n      = winner_n ? a1 : a0;
                    b_n      = winner_n ? b1 : b0;
                    state_n  = S_LOAD;
                end
            end
            S_LOAD:  state_n = S_START;
            S_START: begin
                wd_n    = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                wd_n = wd_inc;
                if (wd_expired) begin
                    err_n   = 1'b1;
                    state_n = S_RESP;
                end else if (done_rise) begin
                    res_n   = sum;
                    state_n = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_RESP && state != S_RESP) begin
            last_n = winner_n;
        end

        ack0_n  = (state_n == S_RESP) && !winner_n;
        ack1_n  = (state_n == S_RESP) && winner_n;
        busy_n  = (state_n != S_IDLE);
        load_n  = (state_n == S_LOAD) || (state_n == S_START);
        start_n = (state_n == S_START);
    end

endmodule

// File: tb/tb_adder_sched.sv
// Randomized and directed bench for adder_sched; the bench plays the adder
// and predicts each transaction's timing and result from the scheduling rules.
module tb_adder_sched;

    localparam int unsigned TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [3:0] sum;
    logic       done;
    logic       ack0, ack1, err, busy, load, start;
    logic [3:0] res, A, B;

    int n_cmp = 0;
    int n_bad = 0;
    int last_served = 1;

    always #5 clk = ~clk;

    // Behavioural adder driven by the scheduler's operand outputs
    assign sum = A + B;

    adder_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
        .load(load), .start(start), .A(A), .B(B),
        .sum(sum), .done(done)
    );

    // One transaction from the negedge where the IDLE scheduler will sample reqs.
    // d: done rises d cycles into WAIT (0 or >= TIMEOUT means the watchdog fires).
    task automatic run_txn(input string name, input int d, input bit hold_done,
                           input bit change_ops, input bit glitch);
        int         w, tack;
        logic [3:0] ea, eb, er;
        logic       ee;
        bit         pre_high;
        logic [9:0] exp_v, got_v;
        w  = (req0 && req1) ? 1 - last_served : (req0 ? 0 : 1);
        ea = (w == 0) ? a0 : a1;
        eb = (w == 0) ? b0 : b1;
        pre_high = done;
        if (d >= 1 && d < int'(TIMEOUT)) begin
            tack = 3 + d;
            er   = ea + eb;
            ee   = 1'b0;
        end else begin
            tack = 3 + int'(TIMEOUT);
            er   = 4'd0;
            ee   = 1'b1;
        end
        for (int t = 1; t <= tack + 1; t++) begin
            @(negedge clk);
            exp_v = {(t == tack) && (w == 0), (t == tack) && (w == 1),
                     (t == tack) ? er : 4'd0, (t == tack) && ee,
                     t <= tack, t <= 2, t == 2};
            got_v = {ack0, ack1, res, err, busy, load, start};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s ctl t=%0d: got %b expected %b (ack0 ack1 res err busy load start)",
                         name, t, got_v, exp_v);
            end
            if (t <= tack) begin
                n_cmp++;
                if ({A, B} !== {ea, eb}) begin
                    n_bad++;
                    $display("FAIL %s operands t=%0d: got A=%0d B=%0d expected A=%0d B=%0d",
                             name, t, A, B, ea, eb);
                end
            end
            if (pre_high && t == 3) done = 1'b0;
            if (d >= 1 && t == 2 + d && t < tack) done = 1'b1;
            if (change_ops && t == 4 && t < tack) begin
                if (w == 0) begin a0 = 4'd9; b0 = 4'd9; end
                else        begin a1 = 4'd9; b1 = 4'd9; end
            end
            if (glitch && t == 4 && t < tack) begin
                if (w == 0) req1 = 1'b1; else req0 = 1'b1;
            end
            if (t == tack) begin
                if (!hold_done) done = 1'b0;
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
                if (glitch) begin
                    if (w == 0) req1 = 1'b0; else req0 = 1'b0;
                end
                last_served = w;
            end
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ack0, ack1, busy, load, start} !== 5'b0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got ack0/ack1/busy/load/start=%b expected 00000",
                         name, i, {ack0, ack1, busy, load, start});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ack0, ack1, res, err, busy, load, start, A, B} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected 0",
                     {ack0, ack1, res, err, busy, load, start, A, B});
        end
        rst_n = 1'b1;
        last_served = 1;
    endtask

    task automatic test_basic();
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd5;
        run_txn("basic_4p5", 10, 1'b0, 1'b0, 1'b0);
        check_idle("basic_after", 3);
    endtask

    task automatic test_tie();
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd7;
        req1 = 1'b1; a1 = 4'd1; b1 = 4'd3;
        run_txn("tie_first", 4, 1'b0, 1'b0, 1'b0);
        run_txn("tie_second", 6, 1'b0, 1'b0, 1'b0);
        req0 = 1'b1; a0 = 4'd12; b0 = 4'd8;
        req1 = 1'b1; a1 = 4'd2;  b1 = 4'd6;
        run_txn("tie_again_first", 3, 1'b0, 1'b0, 1'b0);
        run_txn("tie_again_second", 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        req1 = 1'b1; a1 = 4'd15; b1 = 4'd1;
        run_txn("timeout_nodone", 0, 1'b0, 1'b0, 1'b0);
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
        run_txn("timeout_collide", int'(TIMEOUT), 1'b0, 1'b0, 1'b0);
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd1;
        run_txn("last_before_timeout", int'(TIMEOUT) - 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd6;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack0, ack1, res, err, busy, load, start, A, B} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {ack0, ack1, res, err, busy, load, start, A, B});
        end
        @(negedge clk);
        req0 = 1'b0;
        rst_n = 1'b1;
        last_served = 1;
        check_idle("reset_mid_no_ack", 20);
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd2;
        run_txn("post_reset_2p2", 5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_done_held();
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd7;
        run_txn("held_first", 5, 1'b1, 1'b0, 1'b0);
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd4;
        run_txn("held_second", 6, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_operand_change();
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd5;
        run_txn("operand_change", 8, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_outside_idle();
        req0 = 1'b1; a0 = 4'd1; b0 = 4'd14;
        run_txn("ignore_glitch", 12, 1'b0, 1'b0, 1'b1);
        check_idle("ignore_after", 5);
    endtask

    task automatic test_random();
        int pat;
        for (int i = 0; i < 40; i++) begin
            pat  = int'($urandom_range(1, 3));
            req0 = pat[0];
            req1 = pat[1];
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            run_txn("random_a", int'($urandom_range(1, TIMEOUT + 2)), 1'b0, 1'b0, 1'b0);
            if (req0 || req1)
                run_txn("random_b", int'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_done_held();
        test_operand_change();
        test_ignore_outside_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
